dense_layer_seq: RTL and testbench

//  Parametrised, time-multiplexed fully-connected layer for the chatbot intent classifier.

---
 rtl/dense_layer_seq.sv | 197 +++++++++++++++++++
 tb/tb_dense_layer_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer_seq.sv
// dense_layer_seq: time-multiplexed fully-connected layer.
// One signed MAC per cycle. Weights and bias are loaded at run time. The
// N_OUT results are streamed out one beat at a time, and the argmax class
// index is reported alongside them.
module dense_layer_seq #(
  parameter int N_IN   = 64,
  parameter int N_OUT  = 8,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40,
  parameter int RELU   = 0,
  localparam int WA_W  = $clog2(N_OUT*N_IN+N_OUT),
  localparam int OI_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [WA_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              busy_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [OI_W-1:0]   out_idx_o,
  output logic              out_last_o,
  output logic [OI_W-1:0]   class_idx_o
);

  localparam int W_DEPTH = N_OUT*N_IN;
  localparam int W_AW    = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
  localparam int IC_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int ST_W    = $clog2(N_IN+2);

  localparam logic [IC_W-1:0] IN_LAST    = IC_W'(N_IN-1);
  localparam logic [ST_W-1:0] ST_LASTMAC = ST_W'(N_IN);
  localparam logic [ST_W-1:0] ST_STORE   = ST_W'(N_IN+1);
  localparam logic [OI_W-1:0] NRN_LAST   = OI_W'(N_OUT-1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_OUTPUT} state_e;

  state_e state_q, state_d;

  // Storage: weights, biases, the buffered input vector, and the results.
  logic [DATA_W-1:0] w_mem [W_DEPTH];
  logic [DATA_W-1:0] b_mem [N_OUT];
  logic [DATA_W-1:0] x_mem [N_IN];
  logic [DATA_W-1:0] y_mem [N_OUT];

  logic [IC_W-1:0]          in_cnt_q, in_cnt_d;
  logic [ST_W-1:0]          step_q, step_d;
  logic [OI_W-1:0]          nrn_q, nrn_d;
  logic [OI_W-1:0]          oidx_q, oidx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] best_q, best_d;
  logic [OI_W-1:0]          cls_q, cls_d;

  logic in_hs, out_hs, last_in, wr_ok, store_en, last_nrn;
  logic [IC_W-1:0]          x_sel;
  logic [W_AW-1:0]          w_rd_idx;
  logic signed [DATA_W-1:0] x_rd, w_rd, b_rd;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext, bias_ext, shr;
  logic signed [DATA_W-1:0] r_fin;

  assign in_hs    = in_valid_i & in_ready_o;
  assign out_hs   = out_valid_o & out_ready_i;
  assign last_in  = in_hs && (in_cnt_q == IN_LAST);
  assign last_nrn = (nrn_q == NRN_LAST);
  assign store_en = (state_q == S_COMPUTE) && (step_q == ST_STORE);
  assign wr_ok    = wr_en_i && (state_q == S_IDLE) && (int'(wr_addr_i) < W_DEPTH + N_OUT);

  // MAC operand fetch: step 1..N_IN consumes x[step-1] and W[nrn][step-1].
  assign x_sel    = IC_W'(step_q - ST_W'(1));
  assign w_rd_idx = W_AW'(int'(nrn_q) * N_IN + int'(x_sel));
  assign x_rd     = x_mem[x_sel];
  assign w_rd     = w_mem[w_rd_idx];
  assign b_rd     = b_mem[nrn_q];
  assign prod     = x_rd * w_rd;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W){b_rd[DATA_W-1]}}, b_rd} <<< FRAC_W;
  assign shr      = acc_q >>> FRAC_W;

  // Finalize: floor-shift back to the data format, saturate, then optional ReLU.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    r_fin = shr[DATA_W-1:0];
    if (shr > SAT_MAX)      r_fin = SAT_MAX[DATA_W-1:0];
    else if (shr < SAT_MIN) r_fin = SAT_MIN[DATA_W-1:0];
    if (RELU != 0 && r_fin[DATA_W-1]) r_fin = '0;
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (last_in) state_d = S_COMPUTE;
                 else if (in_hs) state_d = S_LOAD;
      S_LOAD:    if (last_in) state_d = S_COMPUTE;
      S_COMPUTE: if (store_en && last_nrn) state_d = S_OUTPUT;
      S_OUTPUT:  if (out_hs && out_last_o) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode. out_data is forced to zero when no beat is valid.
  always_comb begin
    in_ready_o  = (state_q == S_IDLE) || (state_q == S_LOAD);
    busy_o      = (state_q != S_IDLE);
    out_valid_o = (state_q == S_OUTPUT);
    out_idx_o   = oidx_q;
    out_last_o  = out_valid_o && (oidx_q == NRN_LAST);
    out_data_o  = out_valid_o ? y_mem[oidx_q] : '0;
    class_idx_o = cls_q;
  end

  // Datapath next-state: input counter, per-neuron sequencing, argmax, output index.
  always_comb begin
    in_cnt_d = in_cnt_q;
    step_d   = step_q;
    nrn_d    = nrn_q;
    oidx_d   = oidx_q;
    acc_d    = acc_q;
    best_d   = best_q;
    cls_d    = cls_q;
    if (in_hs) in_cnt_d = last_in ? '0 : in_cnt_q + IC_W'(1);
    // Neuron 0 is seeded in the cycle of the last input, so the compute
    // schedule lands out_valid exactly N_OUT*(N_IN+2) cycles later.
    if (last_in) begin
      acc_d  = bias_ext;
      step_d = ST_W'(1);
    end
    if (state_q == S_COMPUTE) begin
      if (step_q == '0) begin
        acc_d  = bias_ext;
        step_d = ST_W'(1);
      end else if (step_q <= ST_LASTMAC) begin
        acc_d  = acc_q + prod_ext;
        step_d = step_q + ST_W'(1);
      end else begin
        step_d = '0;
        // Strictly greater replaces, so ties keep the lowest index.
        if (nrn_q == '0 || r_fin > best_q) begin
          best_d = r_fin;
          cls_d  = nrn_q;
        end
        nrn_d = last_nrn ? '0 : nrn_q + OI_W'(1);
      end
    end
    if (out_hs) oidx_d = out_last_o ? '0 : oidx_q + OI_W'(1);
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      in_cnt_q <= '0;
      step_q   <= '0;
      nrn_q    <= '0;
      oidx_q   <= '0;
      acc_q    <= '0;
      best_q   <= '0;
      cls_q    <= '0;
    end else begin
      in_cnt_q <= in_cnt_d;
      step_q   <= step_d;
      nrn_q    <= nrn_d;
      oidx_q   <= oidx_d;
      acc_q    <= acc_d;
      best_q   <= best_d;
      cls_q    <= cls_d;
    end
  end

  // Memory writes: parameter loads (IDLE only), input buffering, result store.
  always_ff @(posedge clk_i) begin
    // NOTE: memories have no reset; loaded weights survive a reset, and x/y are only read after being rewritten.
    if (wr_ok) begin
      if (int'(wr_addr_i) < W_DEPTH) w_mem[wr_addr_i[W_AW-1:0]] <= wr_data_i;
      else b_mem[OI_W'(wr_addr_i - WA_W'(W_DEPTH))] <= wr_data_i;
    end
    if (in_hs)    x_mem[in_cnt_q] <= in_data_i;
    if (store_en) y_mem[nrn_q]    <= r_fin;
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed testbench for dense_layer_seq (N_IN=4, N_OUT=2, FRAC_W=8).
// Two instances share all stimulus: one with RELU=0 and one with RELU=1.
module tb_dense_layer_seq;
  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int NW    = N_OUT*N_IN;
  localparam int WA_W  = $clog2(N_OUT*N_IN+N_OUT);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            wr_en = 1'b0;
  logic [WA_W-1:0] wr_addr = '0;
  logic [15:0]     wr_data = '0;
  logic            in_valid = 1'b0;
  logic [15:0]     in_data = '0;
  logic            out_ready = 1'b1;

  logic busy, in_ready, out_valid, out_last;
  logic [15:0] out_data;
  logic [0:0]  out_idx, class_idx;
  logic busy_r, in_ready_r, out_valid_r, out_last_r;
  logic [15:0] out_data_r;
  logic [0:0]  out_idx_r, class_idx_r;

  int checks = 0;
  int failures = 0;

  // Captured results of one output phase.
  logic [15:0] rx_data [4];
  logic [15:0] rx_data_r [4];
  logic        rx_idx [4];
  logic        rx_last [4];
  int          rx_n;
  logic        rx_stable, rx_cls_steady, rx_rdy_next, rdy_seen;
  logic [0:0]  rx_cls, rx_cls_r;

  dense_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(16), .FRAC_W(8), .ACC_W(40), .RELU(0)) dut (
    .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .busy_o(busy), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_idx_o(out_idx), .out_last_o(out_last), .class_idx_o(class_idx));

  dense_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(16), .FRAC_W(8), .ACC_W(40), .RELU(1)) dut_r (
    .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .busy_o(busy_r), .in_valid_i(in_valid), .in_ready_o(in_ready_r), .in_data_i(in_data),
    .out_valid_o(out_valid_r), .out_ready_i(out_ready), .out_data_o(out_data_r),
    .out_idx_o(out_idx_r), .out_last_o(out_last_r), .class_idx_o(class_idx_r));

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [15:0] data);
    wr_en = 1'b1;
    wr_addr = WA_W'(addr);
    wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  task automatic load_params(input logic [15:0] w [NW], input logic [15:0] b [N_OUT]);
    for (int i = 0; i < NW; i++) write_word(i, w[i]);
    for (int o = 0; o < N_OUT; o++) write_word(NW + o, b[o]);
  endtask

  task automatic load_identity();
    logic [15:0] w [NW];
    logic [15:0] b [N_OUT];
    w = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000};
    b = '{16'h0000, 16'h0000};
    load_params(w, b);
  endtask

  // Leaves the bench 1 time unit into the cycle after the last input handshake.
  task automatic send_vector(input logic [15:0] xv [N_IN], input bit hold);
    int wait_c;
    for (int i = 0; i < N_IN; i++) begin
      in_data = xv[i];
      in_valid = 1'b1;
      wait_c = 0;
      while (!in_ready && wait_c < 50) begin
        step();
        wait_c++;
      end
      step();
    end
    if (hold) in_data = 16'h7777;
    else in_valid = 1'b0;
  endtask

  task automatic send_identity_x();
    logic [15:0] xv [N_IN];
    xv = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    send_vector(xv, 1'b0);
  endtask

  // Count cycles (relative to the last input handshake) until out_valid; -1 on timeout.
  task automatic wait_out(input int start, output int lat);
    lat = start;
    rdy_seen = 1'b0;
    while (!out_valid && lat < start + 200) begin
      if (in_ready) rdy_seen = 1'b1;
      step();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  // Collect output beats over a bounded window, optionally stalling beat 0.
  task automatic recv_beats(input int stall_cycles);
    int stalled;
    int post_last;
    logic [15:0] hold_d;
    logic hold_i, hold_l;
    stalled = 0; post_last = 0; rx_n = 0;
    rx_stable = 1'b1; rx_cls_steady = 1'b1; rx_rdy_next = 1'b0;
    hold_d = '0; hold_i = 1'b0; hold_l = 1'b0; rx_cls = '0; rx_cls_r = '0;
    for (int g = 0; g < 40; g++) begin
      if (post_last == 1) begin
        rx_rdy_next = in_ready;
        post_last = 2;
      end
      out_ready = (stalled >= stall_cycles);
      if (out_valid) begin
        if (rx_n == 0 && stalled == 0) rx_cls = class_idx;
        else if (class_idx !== rx_cls) rx_cls_steady = 1'b0;
        if (!out_ready) begin
          if (stalled == 0) begin
            hold_d = out_data; hold_i = out_idx; hold_l = out_last;
          end else if (out_data !== hold_d || out_idx !== hold_i || out_last !== hold_l) begin
            rx_stable = 1'b0;
          end
          stalled++;
        end else begin
          if (stalled > 0 && rx_n == 0 &&
              (out_data !== hold_d || out_idx !== hold_i || out_last !== hold_l)) rx_stable = 1'b0;
          if (rx_n < 4) begin
            rx_data[rx_n] = out_data;
            rx_idx[rx_n] = out_idx;
            rx_last[rx_n] = out_last;
            rx_data_r[rx_n] = out_data_r;
            rx_cls_r = class_idx_r;
          end
          if (out_last) post_last = 1;
          rx_n++;
        end
      end
      step();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
    checks++; if (out_idx !== 1'b0 || class_idx !== 1'b0) begin failures++; $display("FAIL rst_idx: got idx=%b cls=%b want 0/0", out_idx, class_idx); end
    reset = 1'b0;
    step();
    checks++; if (in_ready_r !== 1'b1 || busy_r !== 1'b0) begin failures++; $display("FAIL rst_relu_inst: got rdy=%b busy=%b want 1/0", in_ready_r, busy_r); end
  endtask

  task automatic test_identity();
    int lat;
    load_identity();
    send_identity_x();
    wait_out(1, lat);
    checks++; if (lat != 12) begin failures++; $display("FAIL id_latency: got %0d want 12", lat); end
    recv_beats(0);
    checks++; if (rx_n != 2) begin failures++; $display("FAIL id_beats: got %0d want 2", rx_n); end
    checks++; if (rx_data[0] !== 16'h0100 || rx_data[1] !== 16'h0200) begin failures++; $display("FAIL id_y: got %h %h want 0100 0200", rx_data[0], rx_data[1]); end
    checks++; if (rx_idx[0] !== 1'b0 || rx_idx[1] !== 1'b1) begin failures++; $display("FAIL id_out_idx: got %b %b want 0 1", rx_idx[0], rx_idx[1]); end
    checks++; if (rx_last[0] !== 1'b0 || rx_last[1] !== 1'b1) begin failures++; $display("FAIL id_out_last: got %b %b want 0 1", rx_last[0], rx_last[1]); end
    checks++; if (rx_cls !== 1'b1 || !rx_cls_steady) begin failures++; $display("FAIL id_class: got %b steady=%b want 1 steady=1", rx_cls, rx_cls_steady); end
    checks++; if (rx_data_r[0] !== 16'h0100 || rx_data_r[1] !== 16'h0200) begin failures++; $display("FAIL id_y_relu: got %h %h want 0100 0200", rx_data_r[0], rx_data_r[1]); end
    checks++; if (rx_rdy_next !== 1'b1) begin failures++; $display("FAIL id_ready_after_last: got %b want 1", rx_rdy_next); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL id_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_saturation();
    int lat;
    logic [15:0] w [NW];
    logic [15:0] b [N_OUT];
    logic [15:0] xv [N_IN];
    b = '{16'h0000, 16'h0000};
    xv = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    for (int i = 0; i < NW; i++) w[i] = 16'h7FFF;
    load_params(w, b);
    send_vector(xv, 1'b0);
    wait_out(1, lat);
    recv_beats(0);
    checks++; if (rx_data[0] !== 16'h7FFF || rx_data[1] !== 16'h7FFF) begin failures++; $display("FAIL sat_pos: got %h %h want 7fff 7fff", rx_data[0], rx_data[1]); end
    checks++; if (rx_data_r[0] !== 16'h7FFF || rx_cls !== 1'b0) begin failures++; $display("FAIL sat_pos_relu_cls: got %h cls=%b want 7fff cls=0", rx_data_r[0], rx_cls); end
    for (int i = 0; i < NW; i++) w[i] = 16'h8000;
    load_params(w, b);
    send_vector(xv, 1'b0);
    wait_out(1, lat);
    recv_beats(0);
    checks++; if (rx_data[0] !== 16'h8000 || rx_data[1] !== 16'h8000) begin failures++; $display("FAIL sat_neg: got %h %h want 8000 8000", rx_data[0], rx_data[1]); end
    checks++; if (rx_data_r[0] !== 16'h0000 || rx_data_r[1] !== 16'h0000) begin failures++; $display("FAIL sat_neg_relu: got %h %h want 0000 0000", rx_data_r[0], rx_data_r[1]); end
  endtask

  task automatic test_bias_tie();
    int lat;
    logic [15:0] xv [N_IN];
    xv = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    write_word(NW, 16'h0080);
    write_word(NW + 1, 16'h0080);
    send_vector(xv, 1'b0);
    wait_out(1, lat);
    recv_beats(0);
    checks++; if (rx_data[0] !== 16'h0080 || rx_data[1] !== 16'h0080) begin failures++; $display("FAIL tie_y: got %h %h want 0080 0080", rx_data[0], rx_data[1]); end
    checks++; if (rx_cls !== 1'b0) begin failures++; $display("FAIL tie_class: got %b want 0", rx_cls); end
    write_word(NW, 16'hFF00);
    write_word(NW + 1, 16'h0000);
    send_vector(xv, 1'b0);
    wait_out(1, lat);
    recv_beats(0);
    checks++; if (rx_data[0] !== 16'hFF00 || rx_data[1] !== 16'h0000 || rx_cls !== 1'b1) begin failures++; $display("FAIL negbias: got %h %h cls=%b want ff00 0000 cls=1", rx_data[0], rx_data[1], rx_cls); end
    checks++; if (rx_data_r[0] !== 16'h0000 || rx_data_r[1] !== 16'h0000 || rx_cls_r !== 1'b0) begin failures++; $display("FAIL negbias_relu: got %h %h cls=%b want 0000 0000 cls=0", rx_data_r[0], rx_data_r[1], rx_cls_r); end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] xv [N_IN];
    xv = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    load_identity();
    send_vector(xv, 1'b1);
    wait_out(1, lat);
    in_valid = 1'b0;
    checks++; if (rdy_seen !== 1'b0) begin failures++; $display("FAIL bp_ready_in_compute: got %b want 0", rdy_seen); end
    checks++; if (lat != 12) begin failures++; $display("FAIL bp_latency: got %0d want 12", lat); end
    recv_beats(5);
    checks++; if (rx_stable !== 1'b1) begin failures++; $display("FAIL bp_stable: got %b want 1", rx_stable); end
    checks++; if (rx_n != 2) begin failures++; $display("FAIL bp_beats: got %0d want 2", rx_n); end
    checks++; if (rx_data[0] !== 16'h0100 || rx_data[1] !== 16'h0200 || rx_idx[1] !== 1'b1) begin failures++; $display("FAIL bp_y: got %h %h idx1=%b want 0100 0200 idx1=1", rx_data[0], rx_data[1], rx_idx[1]); end
  endtask

  task automatic test_write_busy();
    int lat;
    send_identity_x();
    write_word(0, 16'h0200);
    wait_out(2, lat);
    recv_beats(0);
    checks++; if (rx_data[0] !== 16'h0100 || rx_data[1] !== 16'h0200 || rx_cls !== 1'b1) begin failures++; $display("FAIL busy_write_dropped: got %h %h cls=%b want 0100 0200 cls=1", rx_data[0], rx_data[1], rx_cls); end
    write_word(0, 16'h0200);
    send_identity_x();
    wait_out(1, lat);
    recv_beats(0);
    checks++; if (rx_data[0] !== 16'h0200 || rx_data[1] !== 16'h0200 || rx_cls !== 1'b0) begin failures++; $display("FAIL idle_write_taken: got %h %h cls=%b want 0200 0200 cls=0", rx_data[0], rx_data[1], rx_cls); end
  endtask

  task automatic test_reset_mid();
    int lat;
    load_identity();
    send_identity_x();
    repeat (4) step();
    reset = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL midrst_state: got ov=%b busy=%b rdy=%b want 0/0/1", out_valid, busy, in_ready); end
    reset = 1'b0;
    step();
    send_identity_x();
    wait_out(1, lat);
    checks++; if (lat != 12) begin failures++; $display("FAIL midrst_latency: got %0d want 12", lat); end
    recv_beats(0);
    checks++; if (rx_n != 2 || rx_data[0] !== 16'h0100 || rx_data[1] !== 16'h0200 || rx_cls !== 1'b1) begin failures++; $display("FAIL midrst_rerun: got n=%0d %h %h cls=%b want n=2 0100 0200 cls=1", rx_n, rx_data[0], rx_data[1], rx_cls); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturation();
    test_bias_tie();
    test_backpressure();
    test_write_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
